// File: rtl/sparc_ifu_sscan_ctl.sv
// Shadow-scan snapshot sequencer: captures a core-state snapshot on an rtap request and returns it as NB beats, starting the cycle after the request.
// No backpressure; requests that arrive during a readout are dropped and flagged sticky. Optional capture timestamp: SSCAN_CTL_TSTAMP_EN.
module sparc_ifu_sscan_ctl #(
  parameter int SNAP_W = 94,
  parameter int BUS_W  = 64,
  parameter int ID_W   = 4,
  parameter int MY_ID  = 1
) (
  input  logic              rclk,
  input  logic              reset,
  input  logic              rtap_core_val,
  input  logic [ID_W-1:0]   rtap_core_id,
  input  logic [1:0]        rtap_core_threadid,
  input  logic [BUS_W-1:0]  rtap_core_data,
  input  logic [SNAP_W-1:0] snap_src_data,
  output logic              core_rtap_val,
  output logic [BUS_W-1:0]  core_rtap_data,
  output logic [2:0]        core_rtap_beat,
  output logic              sscan_busy,
  output logic              sscan_drop
);

`ifdef SSCAN_CTL_TSTAMP_EN
  localparam int TS_W = 18;
`else
  localparam int TS_W = 0;
`endif
  localparam int SNAP_TOT = SNAP_W + TS_W;
  localparam int NB       = (SNAP_TOT + BUS_W - 1) / BUS_W;
  localparam int PAD_W    = NB * BUS_W;

  localparam logic [2:0] LAST_BEAT = 3'(NB - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [1:0] CMD_SNAP    = 2'd0;
  localparam logic [1:0] CMD_REREAD  = 2'd1;
  localparam logic [1:0] CMD_ABORT   = 2'd2;
  localparam logic [1:0] CMD_CLRSTAT = 2'd3;

  logic [0:0]          state_q, state_d;
  logic [2:0]          beat_q, beat_d;
  logic [SNAP_TOT-1:0] snap_q, snap_d;
  logic                snap_vld_q, snap_vld_d;
  logic                drop_q, drop_d;

  logic                hit;
  logic [1:0]          cmd;
  logic                send;
  logic [SNAP_TOT-1:0] cap_dat;
  logic [PAD_W-1:0]    snap_pad;
  logic [BUS_W-1:0]    beat_dat;

  assign hit  = rtap_core_val & (rtap_core_id == ID_W'(MY_ID));
  assign cmd  = rtap_core_data[1:0];
  assign send = (state_q == ST_SEND);

`ifdef SSCAN_CTL_TSTAMP_EN
  logic [15:0] tstamp_q, tstamp_d;
  logic        unused_data;

  assign tstamp_d    = tstamp_q + 16'd1;
  assign cap_dat     = {tstamp_q, rtap_core_threadid, snap_src_data};
  assign unused_data = ^rtap_core_data[BUS_W-1:2];

  always_ff @(posedge rclk) begin
    if (reset) begin
      tstamp_q <= '0;
    end else begin
      tstamp_q <= tstamp_d;
    end
  end
`else
  logic unused_in;

  assign cap_dat   = snap_src_data;
  assign unused_in = ^{rtap_core_data[BUS_W-1:2], rtap_core_threadid};
`endif

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    drop_d     = drop_q;

    if (hit && cmd == CMD_CLRSTAT) begin
      drop_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (hit && cmd == CMD_SNAP) begin
          snap_d     = cap_dat;
          snap_vld_d = 1'b1;
          state_d    = ST_SEND;
          beat_d     = 3'd0;
        end else if (hit && cmd == CMD_REREAD) begin
          state_d = ST_SEND;
          beat_d  = 3'd0;
        end
      end
      default: begin
        if (hit && (cmd == CMD_SNAP || cmd == CMD_REREAD)) begin
          drop_d = 1'b1;
        end
        // Abort still lets this cycle's beat go out; only later beats are cut.
        if ((hit && cmd == CMD_ABORT) || beat_q == LAST_BEAT) begin
          state_d = ST_IDLE;
          beat_d  = 3'd0;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      drop_q     <= drop_d;
    end
  end

  // Zero-padded to a whole number of beats so the top beat reads 0 above SNAP_TOT.
  assign snap_pad = snap_vld_q ? PAD_W'(snap_q) : '0;

  always_comb begin
    beat_dat = '0;
    for (int b = 0; b < NB; b++) begin
      if (beat_q == 3'(b)) begin
        beat_dat = snap_pad[b*BUS_W +: BUS_W];
      end
    end
  end

  assign core_rtap_val  = send;
  assign core_rtap_data = send ? beat_dat : '0;
  assign core_rtap_beat = send ? beat_q : 3'd0;
  assign sscan_busy     = send;
  assign sscan_drop     = drop_q;

endmodule
